// File: rtl/iter_divider_pkg.sv
// Shared CPU defines for the iterative divider and its ALU host.
// State encodings, iteration count and sign helpers.
package iter_divider_pkg;

  localparam int DIV_ITER = 32;
  localparam int CNT_W    = 6;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef struct packed {
    logic neg_q;
    logic neg_r;
    logic dz;
  } div_fix_t;

  function automatic logic [31:0] neg_if(
    input logic        n,
    input logic [31:0] v
  );
    return n ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/iter_divider_if.sv
// Request/response bundle between the ALU and the divider.
// The ALU drives the master side; the divider is the slave.
interface iter_divider_if #(
  parameter int W = 32
);

  logic         div_valid;
  logic         div_signed;
  logic [W-1:0] div_src1;
  logic [W-1:0] div_src2;
  logic         div_ready;
  logic         cancel;
  logic         dout_valid;
  logic [W-1:0] dout_quot;
  logic [W-1:0] dout_rem;
  logic         busy;

  modport master (
    output div_valid,
    output div_signed,
    output div_src1,
    output div_src2,
    output cancel,
    input  div_ready,
    input  dout_valid,
    input  dout_quot,
    input  dout_rem,
    input  busy
  );

  modport slave (
    input  div_valid,
    input  div_signed,
    input  div_src1,
    input  div_src2,
    input  cancel,
    output div_ready,
    output dout_valid,
    output dout_quot,
    output dout_rem,
    output busy
  );

endinterface

// File: rtl/iter_divider.sv
// Radix-2 restoring divider, one quotient bit per cycle, MSB first.
// Handles div/divu on magnitudes and fixes the signs on DONE entry.
module iter_divider
  import iter_divider_pkg::*;
#(
  parameter int DIV_W = 32
) (
  input  logic           clk,
  input  logic           reset,
  iter_divider_if.slave  io
);

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [2*DIV_W-1:0] prem;
  logic [DIV_W-1:0]   dvsr;
  logic [DIV_W-1:0]   quot_q;
  logic [DIV_W-1:0]   rem_q;
  div_fix_t           fix;

  logic st_idle;
  logic st_calc;
  logic st_done;
  logic s1_neg;
  logic s2_neg;
  logic last;

  logic [DIV_W:0]     diff;
  logic [2*DIV_W-1:0] prem_nxt;
  logic [DIV_W-1:0]   quot_fix;
  logic [DIV_W-1:0]   rem_fix;

  assign st_idle = (state == ST_IDLE);
  assign st_calc = (state == ST_CALC);
  assign st_done = (state == ST_DONE);

  assign s1_neg = io.div_signed & io.div_src1[DIV_W-1];
  assign s2_neg = io.div_signed & io.div_src2[DIV_W-1];
  assign last   = (cnt == CNT_W'(DIV_ITER));

  // 33-bit trial subtract: the shifted-out MSB must take part
  always_comb begin
    diff     = prem[2*DIV_W-1:DIV_W-1] - {1'b0, dvsr};
    prem_nxt = {prem[2*DIV_W-2:0], 1'b0};
    if (!diff[DIV_W]) begin
      prem_nxt[2*DIV_W-1:DIV_W] = diff[DIV_W-1:0];
      prem_nxt[0]               = 1'b1;
    end
  end

  // divide by zero keeps the all-ones quotient unsigned
  assign quot_fix = neg_if(fix.neg_q & ~fix.dz,
                           prem[DIV_W-1:0]);
  assign rem_fix  = neg_if(fix.neg_r,
                           prem[2*DIV_W-1:DIV_W]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      prem   <= '0;
      dvsr   <= '0;
      fix    <= '0;
      quot_q <= '0;
      rem_q  <= '0;
    end else if (io.cancel) begin
      state <= ST_IDLE;
    end else begin
      unique case (1'b1)
        st_idle: begin
          if (io.div_valid) begin
            state <= ST_CALC;
            cnt   <= '0;
            prem  <= {{DIV_W{1'b0}},
                      neg_if(s1_neg, io.div_src1)};
            dvsr  <= neg_if(s2_neg, io.div_src2);
            fix   <= '{neg_q: s1_neg ^ s2_neg,
                       neg_r: s1_neg,
                       dz:    io.div_src2 == '0};
          end
        end
        st_calc: begin
          if (last) begin
            state  <= ST_DONE;
            quot_q <= quot_fix;
            rem_q  <= rem_fix;
          end else begin
            prem <= prem_nxt;
            cnt  <= cnt + 1'b1;
          end
        end
        st_done: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign io.div_ready  = st_idle;
  assign io.busy       = st_calc | st_done;
  assign io.dout_valid = st_done;
  assign io.dout_quot  = quot_q;
  assign io.dout_rem   = rem_q;

endmodule

// File: tb/tb_iter_divider.sv
// Bench for iter_divider: scoreboard of expected results
// popped on every dout_valid pulse, plus per-scenario checks.
module tb_iter_divider;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  iter_divider_if #(.W(32)) io();

  iter_divider #(.DIV_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  int vectors = 0;
  int errors  = 0;
  logic [63:0] exp_q[$];

  function automatic logic [63:0] model(
    input logic        s,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [31:0] q;
    logic [31:0] r;
    int signed   sa;
    int signed   sb;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (s) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r};
  endfunction

  always @(negedge clk) begin
    logic [63:0] e;
    if (io.dout_valid) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse got q=%h r=%h required no pulse",
                 io.dout_quot, io.dout_rem);
      end else begin
        e = exp_q.pop_front();
        if ({io.dout_quot, io.dout_rem} !== e) begin
          errors++;
          $display("FAIL scoreboard got q=%h r=%h required q=%h r=%h",
                   io.dout_quot, io.dout_rem, e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic issue(
    input logic        s,
    input logic [31:0] a,
    input logic [31:0] b,
    input bit          push
  );
    io.div_valid  = 1'b1;
    io.div_signed = s;
    io.div_src1   = a;
    io.div_src2   = b;
    @(posedge clk);
    #1;
    io.div_valid  = 1'b0;
    io.div_signed = ~s;
    io.div_src1   = $urandom;
    io.div_src2   = $urandom;
    if (push) exp_q.push_back(model(s, a, b));
  endtask

  task automatic wait_result(output int lat, output bit ready_seen);
    lat        = -1;
    ready_seen = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (io.div_ready) ready_seen = 1'b1;
      if (io.dout_valid) begin
        lat          = i;
        io.div_valid = 1'b0;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    io.div_valid  = 1'b1;
    io.div_signed = 1'b0;
    io.div_src1   = 32'd9;
    io.div_src2   = 32'd3;
    io.cancel     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset        = 1'b0;
    io.div_valid = 1'b0;
    io.cancel    = 1'b0;
    vectors++;
    if ({io.div_ready, io.busy, io.dout_valid} !== 3'b100) begin
      errors++;
      $display("FAIL reset_flags got rdy/busy/vld=%b required 100",
               {io.div_ready, io.busy, io.dout_valid});
    end
    vectors++;
    if ({io.dout_quot, io.dout_rem} !== 64'd0) begin
      errors++;
      $display("FAIL reset_data got q=%h r=%h required 0/0",
               io.dout_quot, io.dout_rem);
    end
  endtask

  task automatic test_unsigned_basic();
    int lat;
    bit rdy;
    issue(1'b0, 32'd100, 32'd7, 1'b1);
    wait_result(lat, rdy);
    vectors++;
    if (lat !== 33) begin
      errors++;
      $display("FAIL latency_100_7 got %0d required 33", lat);
    end
    vectors++;
    if (rdy !== 1'b0) begin
      errors++;
      $display("FAIL ready_low_100_7 got ready=1 required 0");
    end
    vectors++;
    if ({io.dout_quot, io.dout_rem} !== {32'd14, 32'd2}) begin
      errors++;
      $display("FAIL divu_100_7 got q=%h r=%h required q=e r=2",
               io.dout_quot, io.dout_rem);
    end
    vectors++;
    if (io.div_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_done got %b required 1", io.div_ready);
    end
  endtask

  task automatic test_signed_cases();
    logic [31:0] tbl [6][5];
    int lat;
    bit rdy;
    tbl[0] = '{1, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF};
    tbl[1] = '{1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1};
    tbl[2] = '{0, 32'hFFFF_FFF9, 32'd2,        32'h7FFF_FFFC, 32'd1};
    tbl[3] = '{1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
    tbl[4] = '{1, 32'h1234_5678, 32'd0,        32'hFFFF_FFFF, 32'h1234_5678};
    tbl[5] = '{0, 32'h8000_0001, 32'd0,        32'hFFFF_FFFF, 32'h8000_0001};
    for (int i = 0; i < 6; i++) begin
      issue(tbl[i][0][0], tbl[i][1], tbl[i][2], 1'b1);
      wait_result(lat, rdy);
      vectors++;
      if (lat !== 33 || rdy !== 1'b0) begin
        errors++;
        $display("FAIL case%0d_timing got lat=%0d rdy=%b required 33/0",
                 i, lat, rdy);
      end
      vectors++;
      if ({io.dout_quot, io.dout_rem} !== {tbl[i][3], tbl[i][4]}) begin
        errors++;
        $display("FAIL case%0d got q=%h r=%h required q=%h r=%h",
                 i, io.dout_quot, io.dout_rem, tbl[i][3], tbl[i][4]);
      end
    end
  endtask

  task automatic test_cancel_back_to_back();
    logic [63:0] held;
    int lat;
    bit rdy;
    held = {io.dout_quot, io.dout_rem};
    issue(1'b0, 32'd1000, 32'd3, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    vectors++;
    if ({io.busy, io.div_ready} !== 2'b10) begin
      errors++;
      $display("FAIL calc_flags got busy/rdy=%b required 10",
               {io.busy, io.div_ready});
    end
    io.cancel = 1'b1;
    @(posedge clk);
    #1;
    io.cancel = 1'b0;
    vectors++;
    if ({io.div_ready, io.busy, io.dout_valid} !== 3'b100) begin
      errors++;
      $display("FAIL cancel_flags got rdy/busy/vld=%b required 100",
               {io.div_ready, io.busy, io.dout_valid});
    end
    vectors++;
    if ({io.dout_quot, io.dout_rem} !== held) begin
      errors++;
      $display("FAIL cancel_hold got %h required %h",
               {io.dout_quot, io.dout_rem}, held);
    end
    issue(1'b0, 32'd50, 32'd5, 1'b1);
    wait_result(lat, rdy);
    vectors++;
    if (lat !== 33 || {io.dout_quot, io.dout_rem} !== {32'd10, 32'd0}) begin
      errors++;
      $display("FAIL divu_50_5 got lat=%0d q=%h r=%h required 33 q=a r=0",
               lat, io.dout_quot, io.dout_rem);
    end
    io.div_valid  = 1'b1;
    io.div_signed = 1'b0;
    io.div_src1   = 32'd8;
    io.div_src2   = 32'd2;
    io.cancel     = 1'b1;
    @(posedge clk);
    #1;
    io.div_valid = 1'b0;
    io.cancel    = 1'b0;
    vectors++;
    if ({io.div_ready, io.busy} !== 2'b10) begin
      errors++;
      $display("FAIL cancel_priority got rdy/busy=%b required 10",
               {io.div_ready, io.busy});
    end
  endtask

  task automatic test_reset_mid_calc();
    issue(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    reset         = 1'b1;
    io.cancel     = 1'b1;
    io.div_valid  = 1'b1;
    @(posedge clk);
    #1;
    reset        = 1'b0;
    io.cancel    = 1'b0;
    io.div_valid = 1'b0;
    vectors++;
    if ({io.div_ready, io.busy, io.dout_valid,
         io.dout_quot, io.dout_rem} !== {3'b100, 64'd0}) begin
      errors++;
      $display("FAIL reset_mid_calc got rdy/busy/vld=%b q=%h r=%h required 100 0 0",
               {io.div_ready, io.busy, io.dout_valid},
               io.dout_quot, io.dout_rem);
    end
  endtask

  task automatic test_valid_during_calc();
    int lat;
    bit rdy;
    issue(1'b0, 32'hFFFF_FFF9, 32'd2, 1'b1);
    io.div_valid  = 1'b1;
    io.div_signed = 1'b1;
    io.div_src1   = 32'd77;
    io.div_src2   = 32'd5;
    wait_result(lat, rdy);
    vectors++;
    if (lat !== 33 ||
        {io.dout_quot, io.dout_rem} !== {32'h7FFF_FFFC, 32'd1}) begin
      errors++;
      $display("FAIL valid_in_calc got lat=%0d q=%h r=%h required 33 q=7ffffffc r=1",
               lat, io.dout_quot, io.dout_rem);
    end
  endtask

  task automatic test_random();
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    int lat;
    bit rdy;
    for (int i = 0; i < 8; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (i == 3) b = -32'sd13;
      issue(s, a, b, 1'b1);
      wait_result(lat, rdy);
      vectors++;
      if (lat !== 33) begin
        errors++;
        $display("FAIL random%0d_latency got %0d required 33", i, lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_basic();
    test_signed_cases();
    test_cancel_back_to_back();
    test_reset_mid_calc();
    test_valid_during_calc();
    test_random();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending required 0",
               exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/iter_divider.md
ITER_DIVIDER -- requirements
Module: iter_divider

Interface
REQ-001 SHALL have parameter DIV_W, default 32, the operand, quotient and remainder width; only 32 is supported.
REQ-002 SHALL have one clock and one reset: reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 div_valid  input  1  request to start a divide.
REQ-006 div_signed  input  1  1 = signed divide (div), 0 = unsigned divide (divu).
REQ-007 div_src1  input  32  dividend.
REQ-008 div_src2  input  32  divisor.
REQ-009 div_ready  output  1  high only in IDLE; unit can accept a request.
REQ-010 cancel  input  1  pipeline flush from an exception; aborts any operation.
REQ-011 dout_valid  output  1  one-cycle pulse when the result is available.
REQ-012 dout_quot  output  32  quotient.
REQ-013 dout_rem  output  32  remainder.
REQ-014 busy  output  1  high in CALC or DONE.

Function
REQ-015 SHALL implement three states: IDLE, CALC and DONE.
REQ-016 SHALL accept a request on a rising edge where div_valid=1, div_ready=1 and cancel=0, and SHALL move IDLE->CALC on that edge.
REQ-017 SHALL sample div_src1, div_src2 and div_signed only at the accepting edge; operands need not be held afterwards.
REQ-018 On acceptance SHALL latch |src1| and |src2| as 32-bit unsigned values (absolute value only when div_signed=1), plus the sign of the dividend and the sign of the divisor.
REQ-019 In CALC SHALL perform one restoring shift-subtract step per cycle on a 64-bit partial remainder, producing one quotient bit per cycle, MSB first.
REQ-020 SHALL count iterations with a 6-bit counter; after exactly 32 steps, CALC->DONE.
REQ-021 In DONE SHALL assert dout_valid for exactly one cycle, then move DONE->IDLE.
REQ-022 Latency: dout_valid SHALL be high in the cycle following the 33rd rising edge after the accepting edge; the next request can be accepted one cycle after the dout_valid cycle.
REQ-023 Signed result: the quotient SHALL be negated when the dividend and divisor signs differ; the remainder SHALL take the sign of the dividend.
REQ-024 Signed overflow: 0x80000000 / 0xFFFFFFFF SHALL yield quot=0x80000000, rem=0.
REQ-025 Divide by zero (signed or unsigned): SHALL yield quot=0xFFFFFFFF and rem=div_src1 unchanged, with no sign correction and no exception flag.
REQ-026 dout_quot and dout_rem SHALL be registered, updated only on the DONE entry edge, and held until the next DONE entry.
REQ-027 cancel=1 SHALL force the state to IDLE on the next edge from any state, with no dout_valid pulse and dout_quot/dout_rem unchanged.
REQ-028 cancel SHALL take priority over div_valid in the same cycle, so no request is accepted.
REQ-029 div_valid while in CALC or DONE SHALL be ignored, since div_ready=0.

Reset
REQ-030 reset SHALL put the state in IDLE and clear the counter, partial remainder, dout_quot and dout_rem to 0.
REQ-031 After reset: dout_valid=0, busy=0, div_ready=1.
REQ-032 reset SHALL take priority over cancel and div_valid, including when asserted mid-CALC.

Structure
REQ-033 The state encodings (IDLE=2'd0, CALC=2'd1, DONE=2'd2) and DIV_ITER=32 SHALL reside in the shared CPU defines package; the ALU includes the same package.
REQ-034 SHALL be a single module with no sub-modules; one step is combinational logic inside the module.
REQ-035 SHALL be instantiated by the ALU in place of both vendor divider cores, with the ALU consuming {dout_quot, dout_rem} into LO/HI.

Verification
REQ-036 Unsigned 100/7 -> quot=14, rem=2; dout_valid exactly 33 edges after acceptance; div_ready low throughout.
REQ-037 Signed 0xFFFFFFF9/2 (-7/2) -> quot=0xFFFFFFFD, rem=0xFFFFFFFF.
REQ-038 Signed 7/0xFFFFFFFE (7/-2) -> quot=0xFFFFFFFD, rem=1.
REQ-039 Unsigned 0xFFFFFFF9/2 -> quot=0x7FFFFFFC, rem=1.
REQ-040 Signed 0x80000000/0xFFFFFFFF -> quot=0x80000000, rem=0.
REQ-041 Signed 0x12345678/0 -> quot=0xFFFFFFFF, rem=0x12345678.
REQ-042 cancel at the 10th CALC cycle -> no dout_valid pulse, div_ready=1 next cycle; then 50/5 back-to-back -> quot=10, rem=0.
REQ-043 reset mid-CALC -> all outputs 0 and div_ready=1 on the next cycle.
REQ-044 div_valid held high with new operands during CALC -> the running operation is unaffected.
